// File: rtl/fp_operand_sequencer_if.sv
// fp_operand_sequencer_if: host operand/result channels and FP-unit store/acknowledge channels.
// master is the sequencer's view; slave is the host plus FP unit side.
interface fp_operand_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [63:0]            in_a;
    logic [63:0]            in_b;
    logic [63:0]            a;
    logic                   a_store_bit;
    logic                   a_acknowledgment;
    logic [63:0]            b;
    logic                   b_store_bit;
    logic                   b_acknowledgment;
    logic [63:0]            sum;
    logic                   sum_store_bit;
    logic                   sum_acknowledgment;
    logic                   out_valid;
    logic                   out_ready;
    logic [63:0]            out_sum;
    logic                   out_timeout;
    logic                   error;
    logic [$clog2(DEPTH):0] count;

    modport master (
        input  in_valid, in_a, in_b, a_acknowledgment, b_acknowledgment,
               sum, sum_store_bit, out_ready,
        output in_ready, a, a_store_bit, b, b_store_bit, sum_acknowledgment,
               out_valid, out_sum, out_timeout, error, count
    );

    modport slave (
        output in_valid, in_a, in_b, a_acknowledgment, b_acknowledgment,
               sum, sum_store_bit, out_ready,
        input  in_ready, a, a_store_bit, b, b_store_bit, sum_acknowledgment,
               out_valid, out_sum, out_timeout, error, count
    );
endinterface

// File: rtl/fp_operand_sequencer.sv
// fp_operand_sequencer: queues host operand pairs and issues them A-then-B to a non-pipelined FP unit, returning SUMs in order.
// Define RESULT_TIMEOUT_EN to force a NaN timeout result after TIMEOUT cycles without SUM.
module fp_operand_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input logic                   clk,
    input logic                   rst_n,
    fp_operand_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_SUM, HOLD_OUT} state_t;

    state_t      state;
    logic [63:0] mem_a [DEPTH];
    logic [63:0] mem_b [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, push, pop, halted;
    logic [63:0] a_q, b_q, out_sum_q;
    logic        a_sb, b_sb, sum_ack, out_valid_q;

`ifdef RESULT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_q, error_q;
    assign halted          = error_q;
    assign bus.out_timeout = timeout_q;
    assign bus.error       = error_q;
`else
    assign halted          = 1'b0;
    assign bus.out_timeout = 1'b0;
    assign bus.error       = 1'b0;
`endif

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // in_ready is forced low while reset is held so every output reads 0
    assign bus.in_ready = rst_n && !full;
    assign bus.count    = wr_ptr - rd_ptr;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (state == IDLE) && (wr_ptr != rd_ptr) && !halted;

    assign bus.a                  = a_q;
    assign bus.b                  = b_q;
    assign bus.a_store_bit        = a_sb;
    assign bus.b_store_bit        = b_sb;
    assign bus.sum_acknowledgment = sum_ack;
    assign bus.out_valid          = out_valid_q;
    assign bus.out_sum            = out_sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= bus.in_a;
            mem_b[wr_ptr[AW-1:0]] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            a_sb        <= 1'b0;
            b_sb        <= 1'b0;
            sum_ack     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
`ifdef RESULT_TIMEOUT_EN
            tcnt        <= '0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (pop) begin
                    a_q   <= mem_a[rd_ptr[AW-1:0]];
                    b_q   <= mem_b[rd_ptr[AW-1:0]];
                    a_sb  <= 1'b1;
                    state <= SEND_A;
                end
                SEND_A: if (bus.a_acknowledgment) begin
                    a_sb  <= 1'b0;
                    b_sb  <= 1'b1;
                    state <= SEND_B;
                end
                SEND_B: if (bus.b_acknowledgment) begin
                    b_sb    <= 1'b0;
                    sum_ack <= 1'b1;
                    state   <= WAIT_SUM;
`ifdef RESULT_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                // a SUM arriving on the timeout edge takes priority
                WAIT_SUM: if (bus.sum_store_bit) begin
                    out_sum_q   <= bus.sum;
                    out_valid_q <= 1'b1;
                    sum_ack     <= 1'b0;
                    state       <= HOLD_OUT;
`ifdef RESULT_TIMEOUT_EN
                    timeout_q   <= 1'b0;
`endif
                end
`ifdef RESULT_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    out_sum_q   <= 64'hFFF8000000000000;
                    out_valid_q <= 1'b1;
                    timeout_q   <= 1'b1;
                    error_q     <= 1'b1;
                    sum_ack     <= 1'b0;
                    state       <= HOLD_OUT;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
`endif
                HOLD_OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_operand_sequencer.sv
// tb_fp_operand_sequencer: transaction-level model of the sequencer plus an FP-add unit responder, checked every cycle.
module tb_fp_operand_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    typedef struct packed { logic [63:0] a; logic [63:0] b; } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp_operand_sequencer_if #(.DEPTH(DEPTH)) bus ();
    fp_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    pair_t       src_q[$];
    pair_t       fifo_q[$];
    pair_t       cur;
    logic [63:0] res_exp, ua, ub, last_out;
    bit          res_to, a_due, b_due, sum_due, res_due, err, have_b, hold_a, no_sum, junk;
    int          waited, lat, nres, wait_cycles, n0;
    int          total = 0, bad = 0;
    int          in_pct = 100, ack_pct = 100, rdy_pct = 100;

    function automatic logic [63:0] fpadd(logic [63:0] x, logic [63:0] y);
        return $realtobits($bitstoreal(x) + $bitstoreal(y));
    endfunction

    function automatic logic [63:0] rnd_d();
        return $realtobits((real'($urandom_range(4000)) - 2000.0) / 16.0);
    endfunction

    function automatic pair_t rnd_pair();
        pair_t p;
        p.a = rnd_d();
        p.b = rnd_d();
        return p;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // one clock: check DUT against the model, drive host/unit inputs, then advance the model across the coming edge
    task automatic step();
        bit pop;
        @(negedge clk);
        chk("count", bus.count, fifo_q.size());
        chk("in_ready", bus.in_ready, fifo_q.size() != DEPTH);
        chk("a_store_bit", bus.a_store_bit, a_due);
        if (a_due) chk("a", bus.a, cur.a);
        chk("b_store_bit", bus.b_store_bit, b_due);
        if (b_due) chk("b", bus.b, cur.b);
        chk("sum_ack", bus.sum_acknowledgment, sum_due);
        chk("out_valid", bus.out_valid, res_due);
        if (res_due) begin
            chk("out_sum", bus.out_sum, res_exp);
            chk("out_timeout", bus.out_timeout, res_to);
        end
        chk("error", bus.error, err);
        if (bus.sum_acknowledgment) wait_cycles++;
        bus.in_valid = src_q.size() > 0 && $urandom_range(99) < in_pct;
        if (bus.in_valid) begin
            bus.in_a = src_q[0].a;
            bus.in_b = src_q[0].b;
        end else begin
            bus.in_a = rnd_d();
            bus.in_b = rnd_d();
        end
        bus.out_ready        = $urandom_range(99) < rdy_pct;
        bus.a_acknowledgment = !hold_a && $urandom_range(99) < ack_pct;
        bus.b_acknowledgment = $urandom_range(99) < ack_pct;
        if (have_b) begin
            if (lat > 0) lat--;
            bus.sum_store_bit = lat == 0 && !no_sum;
            bus.sum           = fpadd(ua, ub);
        end else begin
            bus.sum_store_bit = junk && !sum_due && $urandom_range(1) == 1;
            bus.sum           = rnd_d();
        end
        pop = !(a_due || b_due || sum_due || res_due) && fifo_q.size() > 0 && !err;
        if (a_due && bus.a_acknowledgment) begin
            a_due = 0; b_due = 1; ua = bus.a;
        end else if (b_due && bus.b_acknowledgment) begin
            b_due = 0; sum_due = 1; waited = 0; ub = bus.b; have_b = 1; lat = $urandom_range(3);
        end else if (sum_due && bus.sum_store_bit) begin
            sum_due = 0; res_due = 1; res_exp = fpadd(cur.a, cur.b); res_to = 0; have_b = 0;
        end
`ifdef RESULT_TIMEOUT_EN
        else if (sum_due && waited == TMO - 1) begin
            sum_due = 0; res_due = 1; res_exp = 64'hFFF8000000000000; res_to = 1; err = 1; have_b = 0;
        end else if (sum_due) begin
            waited++;
        end
`endif
        else if (res_due && bus.out_ready) begin
            res_due = 0; nres++; last_out = bus.out_sum;
        end
        if (pop) begin
            cur = fifo_q.pop_front();
            a_due = 1;
        end
        if (bus.in_valid && bus.in_ready) fifo_q.push_back(src_q.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_a_store", bus.a_store_bit, 0);
        chk("rst_b_store", bus.b_store_bit, 0);
        chk("rst_sum_ack", bus.sum_acknowledgment, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_timeout", bus.out_timeout, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_a", bus.a, 0);
        chk("rst_b", bus.b, 0);
        src_q.delete();
        fifo_q.delete();
        {a_due, b_due, sum_due, res_due, err, have_b, hold_a, no_sum, junk} = '0;
        waited = 0; wait_cycles = 0;
        in_pct = 100; ack_pct = 100; rdy_pct = 100;
        bus.in_valid = 0; bus.out_ready = 0; bus.a_acknowledgment = 0;
        bus.b_acknowledgment = 0; bus.sum_store_bit = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pair_t p[6];
        pair_t q0, q1, r0, r1, r2;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 0;
        bus.a_acknowledgment = 0; bus.b_acknowledgment = 0; bus.sum = 0; bus.sum_store_bit = 0;
        nres = 0; lat = 0; last_out = 0;
        #2 do_reset();
        chk("model_add", fpadd(64'h3FF0000000000000, 64'h4000000000000000), 64'h4008000000000000);
        // single operation, 1.0 + 2.0
        src_q.push_back('{a: 64'h3FF0000000000000, b: 64'h4000000000000000});
        for (int i = 0; i < 50 && nres < 1; i++) step();
        chk("t1_done", nres, 1);
        chk("t1_sum", last_out, 64'h4008000000000000);
        step();
        chk("t1_count", bus.count, 0);
        // full FIFO with the unit refusing A
        hold_a = 1;
        for (int i = 0; i < 6; i++) begin
            p[i] = rnd_pair();
            src_q.push_back(p[i]);
        end
        repeat (12) step();
        chk("t2_count", bus.count, 4);
        chk("t2_in_ready", bus.in_ready, 0);
        chk("t2_a_store", bus.a_store_bit, 1);
        chk("t2_a", bus.a, p[0].a);
        chk("t2_stalled", src_q.size(), 1);
        hold_a = 0;
        n0 = nres;
        for (int i = 0; i < 300 && nres < n0 + 6; i++) step();
        chk("t2_done", nres - n0, 6);
        chk("t2_last", last_out, fpadd(p[5].a, p[5].b));
        // host backpressure for 20 cycles
        rdy_pct = 0;
        n0 = nres;
        q0 = rnd_pair(); q1 = rnd_pair();
        src_q.push_back(q0); src_q.push_back(q1);
        for (int i = 0; i < 50 && !res_due; i++) step();
        step();
        chk("t3_valid", bus.out_valid, 1);
        repeat (20) step();
        chk("t3_hold_sum", bus.out_sum, fpadd(q0.a, q0.b));
        chk("t3_hold_valid", bus.out_valid, 1);
        chk("t3_no_a", bus.a_store_bit, 0);
        chk("t3_no_sum_ack", bus.sum_acknowledgment, 0);
        chk("t3_count", bus.count, 1);
        rdy_pct = 100;
        for (int i = 0; i < 100 && nres < n0 + 2; i++) step();
        chk("t3_done", nres - n0, 2);
        chk("t3_last", last_out, fpadd(q1.a, q1.b));
        // push and pop on the same edge
        rdy_pct = 0;
        n0 = nres;
        r0 = rnd_pair(); r1 = rnd_pair(); r2 = rnd_pair();
        src_q.push_back(r0); src_q.push_back(r1);
        for (int i = 0; i < 60 && !(res_due && fifo_q.size() == 1); i++) step();
        step();
        chk("t4_count_pre", bus.count, 1);
        in_pct = 0;
        src_q.push_back(r2);
        rdy_pct = 100;
        step();
        in_pct = 100;
        step();
        step();
        chk("t4_count", bus.count, 1);
        chk("t4_a_store", bus.a_store_bit, 1);
        chk("t4_a", bus.a, r1.a);
        for (int i = 0; i < 100 && nres < n0 + 3; i++) step();
        chk("t4_done", nres - n0, 3);
        chk("t4_last", last_out, fpadd(r2.a, r2.b));
        // reset while waiting for SUM with two pairs queued
        no_sum = 1;
        for (int i = 0; i < 3; i++) src_q.push_back(rnd_pair());
        for (int i = 0; i < 40 && !(sum_due && fifo_q.size() == 2); i++) step();
        step();
        chk("t5_count", bus.count, 2);
        chk("t5_sum_ack", bus.sum_acknowledgment, 1);
        do_reset();
        repeat (20) step();
        chk("t5_no_out", bus.out_valid, 0);
        chk("t5_no_a", bus.a_store_bit, 0);
        // randomized traffic with spurious SUM strobes
        junk = 1;
        n0 = nres;
        for (int i = 0; i < 150; i++) src_q.push_back(rnd_pair());
        for (int i = 0; i < 20000 && nres < n0 + 150; i++) begin
            if (i % 16 == 0) begin
                in_pct  = $urandom_range(20, 100);
                ack_pct = $urandom_range(20, 100);
                rdy_pct = $urandom_range(20, 100);
            end
            step();
        end
        chk("rand_done", nres - n0, 150);
`ifdef RESULT_TIMEOUT_EN
        step();
        do_reset();
        no_sum = 1;
        src_q.push_back(rnd_pair());
        src_q.push_back(rnd_pair());
        for (int i = 0; i < 100 && !res_due; i++) step();
        step();
        chk("t6_sum", bus.out_sum, 64'hFFF8000000000000);
        chk("t6_timeout", bus.out_timeout, 1);
        chk("t6_error", bus.error, 1);
        chk("t6_wait_cycles", wait_cycles, 16);
        repeat (10) step();
        chk("t6_no_issue", bus.a_store_bit, 0);
        chk("t6_count", bus.count, 1);
        chk("t6_error_sticky", bus.error, 1);
`else
        chk("no_timeout_flag", bus.out_timeout, 0);
        chk("no_error_flag", bus.error, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
